// File: rtl/smol_pkg.sv
// Shared types and helpers for the smol load/store unit.
// Holds access size and FSM state enums plus offset alignment helpers.
package smol_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_t;

  function automatic logic misaligned(
    input lsu_size_t  s,
    input logic [1:0] a
  );
    return ((s == HALF) && a[0]) ||
           ((s == WORD) && (a != 2'b00));
  endfunction

  function automatic logic [1:0] align_off(
    input lsu_size_t  s,
    input logic [1:0] a
  );
    logic [1:0] r;
    r = a;
    unique case (1'b1)
      (s == HALF): r = {a[1], 1'b0};
      (s == WORD): r = 2'b00;
      default:     r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/smol_lsu_align.sv
// Byte-lane steering: store strobes/replication and load extraction.
// Ports: size_i, off_i, uns_i, rdata_i, wdata_i -> wstrb_o, wdata_rep_o, load_data_o.
module smol_lsu_align
  import smol_pkg::*;
(
  input  lsu_size_t   size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] load_data_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    wstrb_o     = 4'b0000;
    wdata_rep_o = wdata_i;
    load_data_o = sh;
    unique case (1'b1)
      (size_i == BYTE): begin
        wstrb_o     = 4'b0001 << off_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        load_data_o = uns_i ? {24'h0, sh[7:0]}
                            : {{24{sh[7]}}, sh[7:0]};
      end
      (size_i == HALF): begin
        wstrb_o     = 4'b0011 << off_i;
        wdata_rep_o = {2{wdata_i[15:0]}};
        load_data_o = uns_i ? {16'h0, sh[15:0]}
                            : {{16{sh[15]}}, sh[15:0]};
      end
      (size_i == WORD): begin
        wstrb_o     = 4'b1111;
        wdata_rep_o = wdata_i;
        load_data_o = sh;
      end
      default: begin
        wstrb_o     = 4'b0000;
        wdata_rep_o = wdata_i;
        load_data_o = sh;
      end
    endcase
  end

endmodule

// File: rtl/smol_lsu.sv
// Load/store unit: one outstanding access, IDLE/REQ/WAIT FSM with timeout.
// Ports: req_* from execute, mem_* bus, wb_* load writeback, done/fault/fault_addr.
// Macro SMOL_LSU_MISALIGN_TRAP_EN: misaligned half/word faults instead of aligning.
module smol_lsu
  import smol_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t  state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] addr_q;
  logic [1:0]  off_q;
  lsu_size_t   size_q;
  logic        we_q;
  logic        uns_q;
  logic [4:0]  rd_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  lsu_size_t   size_d;
  logic [1:0]  off_d;
  logic        bad_d;
  logic        tmo;
  logic [3:0]  strb;
  logic [31:0] wrep;
  logic [31:0] ldata;

  assign size_d = lsu_size_t'(req_size);

`ifdef SMOL_LSU_MISALIGN_TRAP_EN
  assign off_d = req_addr[1:0];
  assign bad_d = (size_d == ILLEGAL) ||
                 misaligned(size_d, req_addr[1:0]);
`else
  assign off_d = align_off(size_d, req_addr[1:0]);
  assign bad_d = (size_d == ILLEGAL);
`endif

  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  smol_lsu_align u_align (
    .size_i      (size_q),
    .off_i       (off_q),
    .uns_i       (uns_q),
    .rdata_i     (mem_rdata),
    .wdata_i     (wdata_q),
    .wstrb_o     (strb),
    .wdata_rep_o (wrep),
    .load_data_o (ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      off_q        <= '0;
      size_q       <= BYTE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      rd_q         <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            off_q   <= off_d;
            size_q  <= size_d;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            rd_q    <= req_rd;
            wdata_q <= req_wdata;
            if (bad_d) begin
              fault_q      <= 1'b1;
              done_q       <= 1'b1;
              fault_addr_q <= req_addr;
            end else begin
              state_q <= REQ;
              cnt_q   <= '0;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ready) begin
            if (we_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end else if (tmo) begin
            state_q      <= IDLE;
            fault_q      <= 1'b1;
            done_q       <= 1'b1;
            fault_addr_q <= addr_q;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rvalid) begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            wb_valid_q <= (rd_q != 5'd0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= ldata;
          end else if (tmo) begin
            state_q      <= IDLE;
            fault_q      <= 1'b1;
            done_q       <= 1'b1;
            fault_addr_q <= addr_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_valid  = (state_q == REQ);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_we     = we_q;
  // strobes only meaningful for a store on the bus
  assign mem_wstrb  = (mem_valid && we_q) ? strb : 4'b0000;
  assign mem_wdata  = wrep;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_smol_lsu.sv
// Scoreboard bench for smol_lsu: driver pushes expectations, monitor checks.
// Latency is counted in edges from acceptance to the edge that registers the pulse.
module tb_smol_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        fault;
  logic [31:0] fault_addr;

  smol_lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .done(done), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        fault;
    logic [31:0] faddr;
    logic        wbv;
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic pb(input logic [31:0] a, input logic we,
                    input logic [3:0] s, input logic [31:0] d);
    bus_t b;
    b.addr = a; b.we = we; b.strb = s; b.wdata = d;
    bus_q.push_back(b);
  endtask

  task automatic pr(input logic f, input logic [31:0] fa,
                    input logic wbv, input logic [4:0] rd,
                    input logic [31:0] d, input int lat);
    res_t r;
    r.fault = f; r.faddr = fa; r.wbv = wbv;
    r.rd = rd; r.data = d; r.lat = lat;
    res_q.push_back(r);
  endtask

  // monitor: bus request stability/handshake and completion pulses
  always @(negedge clk) begin
    if (!rst && mem_valid) begin
      if (bus_q.size() == 0) begin
        chk("unexpected mem_valid", 32'(mem_valid), 32'd0);
      end else begin
        chk("mem_addr", mem_addr, bus_q[0].addr);
        chk("mem_we", 32'(mem_we), 32'(bus_q[0].we));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(bus_q[0].strb));
        if (bus_q[0].we)
          chk("mem_wdata", mem_wdata, bus_q[0].wdata);
        if (mem_ready) void'(bus_q.pop_front());
      end
    end
    if (!rst && (done || fault || wb_valid)) begin
      if (res_q.size() == 0) begin
        chk("unexpected done", 32'(done), 32'd0);
        chk("unexpected wb_valid", 32'(wb_valid), 32'd0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("done", 32'(done), 32'd1);
        chk("fault", 32'(fault), 32'(r.fault));
        if (r.fault) chk("fault_addr", fault_addr, r.faddr);
        chk("wb_valid", 32'(wb_valid), 32'(r.wbv));
        if (r.wbv) begin
          chk("wb_rd", 32'(wb_rd), 32'(r.rd));
          chk("wb_data", wb_data, r.data);
        end
        chk("latency", 32'(cyc - acc), 32'(r.lat));
      end
    end
  end

  task automatic drain(input bit drop_bus);
    int n;
    n = 0;
    while (res_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (res_q.size() != 0) begin
      chk("completion wait expired", 32'(res_q.size()), 32'd0);
      res_q.delete();
    end
    repeat (2) @(posedge clk);
    if (drop_bus) bus_q.delete();
    if (bus_q.size() != 0) begin
      chk("bus handshake missing", 32'(bus_q.size()), 32'd0);
      bus_q.delete();
    end
  endtask

  // rlat < 0: bus never ready; bus == 0: no bus access expected
  task automatic op(input logic we, input logic [1:0] sz,
                    input logic uns, input logic [31:0] a,
                    input logic [31:0] wd, input logic [4:0] rd,
                    input bit bus, input int rlat,
                    input logic [31:0] rdata);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
    if (bus && rlat >= 0) begin
      repeat (rlat) @(posedge clk);
      #1 mem_ready = 1'b1;
      @(posedge clk); #1 mem_ready = 1'b0;
      if (!we) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1 mem_rvalid = 1'b0;
      end
    end
    drain(rlat < 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst mem_valid", 32'(mem_valid), 32'd0);
    chk("rst outs", {done, fault, wb_valid, mem_we, mem_wstrb},
        32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst fault_addr", fault_addr, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // sw 0x100
    pb(32'h100, 1'b1, 4'hF, 32'hDEADBEEF);
    pr(1'b0, 0, 1'b0, 0, 0, 1);
    op(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0, 1, 0, 0);

    // lb / lbu 0x103
    pb(32'h100, 1'b0, 4'h0, 0);
    pr(1'b0, 0, 1'b1, 5'd5, 32'hFFFFFF80, 2);
    op(1'b0, 2'b00, 1'b0, 32'h103, 0, 5'd5, 1, 0, 32'h80000000);
    pb(32'h100, 1'b0, 4'h0, 0);
    pr(1'b0, 0, 1'b1, 5'd6, 32'h00000080, 2);
    op(1'b0, 2'b00, 1'b1, 32'h103, 0, 5'd6, 1, 0, 32'h80000000);

    // sh 0x102 with two wait cycles before ready
    pb(32'h100, 1'b1, 4'b1100, 32'h12341234);
    pr(1'b0, 0, 1'b0, 0, 0, 3);
    op(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234, 5'd0, 1, 2, 0);

    // sb 0x101
    pb(32'h100, 1'b1, 4'b0010, 32'hABABABAB);
    pr(1'b0, 0, 1'b0, 0, 0, 1);
    op(1'b1, 2'b00, 1'b0, 32'h101, 32'hAB, 5'd0, 1, 0, 0);

    // lh / lhu 0x102
    pb(32'h100, 1'b0, 4'h0, 0);
    pr(1'b0, 0, 1'b1, 5'd9, 32'hFFFF8765, 2);
    op(1'b0, 2'b01, 1'b0, 32'h102, 0, 5'd9, 1, 0, 32'h87654321);
    pb(32'h000, 1'b0, 4'h0, 0);
    pr(1'b0, 0, 1'b1, 5'd10, 32'h00008765, 2);
    op(1'b0, 2'b01, 1'b1, 32'h002, 0, 5'd10, 1, 0, 32'h87654321);

    // lw to x0: done without wb_valid
    pb(32'h104, 1'b0, 4'h0, 0);
    pr(1'b0, 0, 1'b0, 0, 0, 2);
    op(1'b0, 2'b10, 1'b0, 32'h104, 0, 5'd0, 1, 0, 32'h11223344);

    // illegal size
    pr(1'b1, 32'h200, 1'b0, 0, 0, 0);
    op(1'b0, 2'b11, 1'b0, 32'h200, 0, 5'd3, 0, 0, 0);

`ifdef SMOL_LSU_MISALIGN_TRAP_EN
    pr(1'b1, 32'h101, 1'b0, 0, 0, 0);
    op(1'b0, 2'b10, 1'b0, 32'h101, 0, 5'd7, 0, 0, 0);
    pr(1'b1, 32'h103, 1'b0, 0, 0, 0);
    op(1'b0, 2'b01, 1'b0, 32'h103, 0, 5'd8, 0, 0, 0);
`else
    pb(32'h100, 1'b0, 4'h0, 0);
    pr(1'b0, 0, 1'b1, 5'd7, 32'hCAFEF00D, 2);
    op(1'b0, 2'b10, 1'b0, 32'h101, 0, 5'd7, 1, 0, 32'hCAFEF00D);
    pb(32'h100, 1'b0, 4'h0, 0);
    pr(1'b0, 0, 1'b1, 5'd8, 32'hFFFFBEEF, 2);
    op(1'b0, 2'b01, 1'b0, 32'h103, 0, 5'd8, 1, 0, 32'hBEEF0000);
`endif

    // timeout: mem_ready never asserted
    pb(32'h300, 1'b1, 4'hF, 32'h55AA55AA);
    pr(1'b1, 32'h300, 1'b0, 0, 0, 16);
    op(1'b1, 2'b10, 1'b0, 32'h300, 32'h55AA55AA, 5'd0, 1, -1, 0);
    @(negedge clk);
    chk("idle after timeout", 32'(req_ready), 32'd1);

    // reset while in WAIT, late rvalid must be ignored
    pb(32'h400, 1'b0, 4'h0, 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h400; req_rd = 5'd4;
    @(posedge clk); #1;
    req_valid = 1'b0; acc = cyc; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst-wait mem_valid", 32'(mem_valid), 32'd0);
    chk("rst-wait req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst-wait wb_valid", 32'(wb_valid), 32'd0);
    chk("rst-wait bus queue", 32'(bus_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
